// File: rtl/cavlc_mb_sequencer_pkg.sv
// cavlc_pkg: shared types, widths and block-geometry/nC helpers for the CAVLC macroblock sequencer
package cavlc_pkg;
   typedef enum logic [2:0] {IDLE, FETCH, CALC, ISSUE, WAIT, UPDATE, DONE} state_t;
   localparam int TC_W = 5;
   localparam int NC_MAX = 16;
   function automatic logic [1:0] blk_x(input logic [3:0] idx);
      return {idx[2], idx[0]};
   endfunction
   function automatic logic [1:0] blk_y(input logic [3:0] idx);
      return {idx[3], idx[1]};
   endfunction
   function automatic logic [3:0] blk_idx(input logic [1:0] x, input logic [1:0] y);
      return {y[1], x[1], y[0], x[0]};
   endfunction
   function automatic logic [TC_W-1:0] nc_avg(input logic [TC_W-1:0] a, input logic [TC_W-1:0] b,
                                              input logic aOk, input logic bOk);
      logic [5:0] s;
      s = {1'b0, a} + {1'b0, b} + 6'd1;
      return (aOk && bOk) ? s[5:1] : aOk ? a : bOk ? b : '0;
   endfunction
endpackage

// File: rtl/cavlc_mb_sequencer_if.sv
// cavlc_mb_sequencer_if: slice-parser and CAVLC-core handshake signals around the macroblock sequencer
interface cavlc_mb_sequencer_if #(parameter int MBX_W = 7);
   logic             MbStart;
   logic [MBX_W-1:0] MbX;
   logic             MbAvailLeft;
   logic             MbAvailTop;
   logic             MbBusy;
   logic             MbDone;
   logic             BlkStart;
   logic [3:0]       BlkIdx;
   logic [4:0]       nC;
   logic             BlkDone;
   logic [4:0]       BlkTotalCoeff;
   logic             Error;
   modport master (
      output MbStart, MbX, MbAvailLeft, MbAvailTop, BlkDone, BlkTotalCoeff,
      input  MbBusy, MbDone, BlkStart, BlkIdx, nC, Error
   );
   modport slave (
      input  MbStart, MbX, MbAvailLeft, MbAvailTop, BlkDone, BlkTotalCoeff,
      output MbBusy, MbDone, BlkStart, BlkIdx, nC, Error
   );
endinterface

// File: rtl/cavlc_mb_sequencer_linebuf.sv
// cavlc_nc_linebuf: single-port synchronous RAM holding each MB column's bottom-row TotalCoeffs
module cavlc_nc_linebuf #(
   parameter int DEPTH = 120,
   parameter int AW = $clog2(DEPTH),
   parameter int DW = 20
) (
   input  logic          Clk,
   input  logic          We,
   input  logic          Re,
   input  logic [AW-1:0] Addr,
   input  logic [DW-1:0] WrData,
   output logic [DW-1:0] RdData
);
   logic [DW-1:0] mem [DEPTH];
   always_ff @(posedge Clk) begin
      if (We) mem[Addr] <= WrData;
      else if (Re) RdData <= mem[Addr];
   end
endmodule

// File: rtl/cavlc_mb_sequencer.sv
// cavlc_mb_sequencer: steps the CAVLC core through the 16 luma blocks of a macroblock,
// deriving nC for each block from left/top neighbour TotalCoeffs.
module cavlc_mb_sequencer
   import cavlc_pkg::*;
#(
   parameter int MB_WIDTH_MAX = 120,
   parameter int MBX_W = $clog2(MB_WIDTH_MAX)
) (
   input logic Clk,
   input logic Reset,
   cavlc_mb_sequencer_if.slave bus
);
   state_t                  state, stateNext;
   logic [MBX_W-1:0]        mbX;
   logic                    availLeft, availTop, error, mbOk, aOk, bOk;
   logic [3:0]              blkIdx;
   logic [TC_W-1:0]         ncReg, tcIn, nA, nB;
   logic [15:0][TC_W-1:0]   tc;
   logic [3:0][TC_W-1:0]    leftTc, topWord, bottomWord;
   logic [1:0]              bx, by;

   assign mbOk = int'(bus.MbX) < MB_WIDTH_MAX;
   assign bx = blk_x(blkIdx);
   assign by = blk_y(blkIdx);
   assign aOk = (bx != 2'd0) || availLeft;
   assign bOk = (by != 2'd0) || availTop;
   assign nA = (bx != 2'd0) ? tc[blk_idx(bx - 2'd1, by)] : leftTc[by];
   assign nB = (by != 2'd0) ? tc[blk_idx(bx, by - 2'd1)] : topWord[bx];
   assign bottomWord = {tc[15], tc[14], tc[11], tc[10]};

   // the word read in FETCH is held in the RAM output register for every later CALC of this MB
   cavlc_nc_linebuf #(.DEPTH(MB_WIDTH_MAX), .AW(MBX_W), .DW(4*TC_W)) u_linebuf (
      .Clk(Clk),
      .We(state == DONE),
      .Re(state == FETCH),
      .Addr(mbX),
      .WrData(bottomWord),
      .RdData(topWord)
   );

   assign bus.MbBusy = state != IDLE;
   assign bus.MbDone = state == DONE;
   assign bus.BlkStart = state == ISSUE;
   assign bus.BlkIdx = blkIdx;
   assign bus.nC = ncReg;
   assign bus.Error = error;

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    stateNext = (bus.MbStart && mbOk) ? FETCH : IDLE;
         FETCH:   stateNext = CALC;
         CALC:    stateNext = ISSUE;
         ISSUE:   stateNext = WAIT;
         WAIT:    stateNext = bus.BlkDone ? UPDATE : WAIT;
         UPDATE:  stateNext = (blkIdx == 4'd15) ? DONE : CALC;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         mbX <= '0;
         availLeft <= 1'b0;
         availTop <= 1'b0;
         blkIdx <= '0;
         ncReg <= '0;
         tcIn <= '0;
         error <= 1'b0;
         tc <= '0;
         leftTc <= '0;
      end else begin
         if (state == IDLE && bus.MbStart) begin
            if (mbOk) begin
               mbX <= bus.MbX;
               availLeft <= bus.MbAvailLeft;
               availTop <= bus.MbAvailTop;
            end else error <= 1'b1;
         end
         if (state == FETCH) blkIdx <= '0;
         if (state == CALC) ncReg <= nc_avg(nA, nB, aOk, bOk);
         if (state == WAIT && bus.BlkDone) begin
            tcIn <= (bus.BlkTotalCoeff > NC_MAX) ? TC_W'(NC_MAX) : bus.BlkTotalCoeff;
            if (bus.BlkTotalCoeff > NC_MAX) error <= 1'b1;
         end
         if (state == UPDATE) begin
            tc[blkIdx] <= tcIn;
            if (blkIdx != 4'd15) blkIdx <= blkIdx + 4'd1;
         end
         // right column of this MB becomes the left context of the next one
         if (state == DONE) leftTc <= {tc[15], tc[13], tc[7], tc[5]};
      end
   end
endmodule

// File: tb/tb_cavlc_mb_sequencer.sv
// tb_cavlc_mb_sequencer: directed and randomized macroblocks checked against an array-based neighbour model
module tb_cavlc_mb_sequencer;
   localparam int MBW = 120;
   localparam int XW = $clog2(MBW);

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   cavlc_mb_sequencer_if #(.MBX_W(XW)) bus ();
   cavlc_mb_sequencer #(.MB_WIDTH_MAX(MBW), .MBX_W(XW)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

   always #5 Clk = ~Clk;

   int nChk = 0;
   int nPass = 0;
   int mtc [4][4];
   int refLeft [4];
   int refLine [MBW][4];
   bit lineOk [MBW];
   bit refErr;
   int tcs [16];

   task automatic check(input string tag, input int got, input int exp);
      nChk++;
      if (got == exp) nPass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic refReset();
      for (int i = 0; i < 4; i++) refLeft[i] = 0;
      refErr = 1'b0;
   endtask

   function automatic int posX(input int b);
      return ((b >> 2) & 1) * 2 + (b & 1);
   endfunction
   function automatic int posY(input int b);
      return ((b >> 3) & 1) * 2 + ((b >> 1) & 1);
   endfunction

   function automatic int refNc(input int b, input bit al, input bit at, input int mbx);
      int x, y, a, t;
      bit aOk, tOk;
      x = posX(b);
      y = posY(b);
      aOk = x > 0 || al;
      tOk = y > 0 || at;
      a = x > 0 ? mtc[x-1][y] : refLeft[y];
      t = y > 0 ? mtc[x][y-1] : refLine[mbx][x];
      if (aOk && tOk) return (a + t + 1) / 2;
      if (aOk) return a;
      if (tOk) return t;
      return 0;
   endfunction

   task automatic checkAllZero();
      check("rstBusy", bus.MbBusy, 0);
      check("rstDone", bus.MbDone, 0);
      check("rstStart", bus.BlkStart, 0);
      check("rstIdx", bus.BlkIdx, 0);
      check("rstNc", bus.nC, 0);
      check("rstErr", bus.Error, 0);
   endtask

   task automatic doReset();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      refReset();
      checkAllZero();
   endtask

   // starts in the cycle MbStart is driven; returns in the first IDLE cycle after MbDone
   task automatic runMb(input int mbx, input bit al, input bit at, input bit spur, input int abortAt, input int maxDly);
      bus.MbStart = 1'b1;
      bus.MbX = XW'(mbx);
      bus.MbAvailLeft = al;
      bus.MbAvailTop = at;
      tick();
      bus.MbStart = 1'b0;
      bus.MbAvailLeft = ~al;
      bus.MbAvailTop = ~at;
      check("busyRise", bus.MbBusy, 1);
      check("startEarly", bus.BlkStart, 0);
      tick();
      if (spur) begin
         bus.BlkDone = 1'b1;
         bus.BlkTotalCoeff = 5'd9;
         bus.MbStart = 1'b1;
         bus.MbX = XW'((mbx + 1) % MBW);
      end
      check("startEarly2", bus.BlkStart, 0);
      tick();
      for (int b = 0; b < 16; b++) begin
         int d;
         check("blkStart", bus.BlkStart, 1);
         check("blkIdx", bus.BlkIdx, b);
         check($sformatf("nC[%0d]", b), bus.nC, refNc(b, al, at, mbx));
         tick();
         bus.BlkDone = 1'b0;
         bus.MbStart = 1'b0;
         if (b == abortAt) begin
            Reset = 1'b1;
            tick();
            Reset = 1'b0;
            refReset();
            checkAllZero();
            return;
         end
         check("startPulse", bus.BlkStart, 0);
         d = $urandom_range(maxDly);
         repeat (d) begin
            tick();
            check("waitHold", bus.BlkIdx + 16 * bus.BlkStart, b);
         end
         bus.BlkDone = 1'b1;
         bus.BlkTotalCoeff = 5'(tcs[b]);
         mtc[posX(b)][posY(b)] = tcs[b] > 16 ? 16 : tcs[b];
         if (tcs[b] > 16) refErr = 1'b1;
         tick();
         bus.BlkDone = 1'b0;
         bus.BlkTotalCoeff = 5'($urandom_range(31));
         check("startGap", bus.BlkStart, 0);
         tick();
         check("mbDone", bus.MbDone, int'(b == 15));
         tick();
         if (b == 15) check("busyFall", bus.MbBusy, 0);
      end
      for (int i = 0; i < 4; i++) begin
         refLine[mbx][i] = mtc[i][3];
         refLeft[i] = mtc[3][i];
      end
      lineOk[mbx] = 1'b1;
      check("error", bus.Error, int'(refErr));
   endtask

   initial begin
      bus.MbStart = 1'b0;
      bus.MbX = '0;
      bus.MbAvailLeft = 1'b0;
      bus.MbAvailTop = 1'b0;
      bus.BlkDone = 1'b0;
      bus.BlkTotalCoeff = '0;
      tick();
      doReset();

      for (int i = 0; i < 16; i++) tcs[i] = 2;
      tcs[0] = 3;
      tcs[1] = 4;
      tcs[2] = 5;
      runMb(0, 0, 0, 0, -1, 0);
      for (int i = 0; i < 16; i++) tcs[i] = 2;
      runMb(0, 0, 0, 1, -1, 2);
      runMb(1, 1, 0, 0, -1, 1);
      runMb(0, 0, 1, 1, -1, 0);
      runMb(0, 0, 1, 0, -1, 0);

      tcs[0] = 20;
      runMb(5, 1, 0, 0, -1, 1);
      tcs[0] = 2;
      runMb(6, 1, 0, 0, -1, 0);
      doReset();

      bus.MbStart = 1'b1;
      bus.MbX = XW'(MBW);
      tick();
      bus.MbStart = 1'b0;
      refErr = 1'b1;
      check("badBusy", bus.MbBusy, 0);
      check("badErr", bus.Error, 1);
      tick();
      check("badBusy2", bus.MbBusy, 0);
      doReset();

      repeat (25) begin
         int mbx;
         bit al, at;
         mbx = ($urandom_range(3) == 0) ? $urandom_range(MBW - 1) : $urandom_range(3);
         al = 1'($urandom_range(1));
         at = lineOk[mbx] & 1'($urandom_range(1));
         for (int i = 0; i < 16; i++) tcs[i] = ($urandom_range(11) == 0) ? $urandom_range(31) : $urandom_range(16);
         runMb(mbx, al, at, 1'($urandom_range(1)), -1, 3);
      end

      for (int i = 0; i < 16; i++) tcs[i] = $urandom_range(16);
      runMb(2, 1, lineOk[2], 0, 7, 1);
      tick();
      runMb(0, 0, 0, 0, -1, 1);

      $display("%0d/%0d checks passed", nPass, nChk);
      $finish;
   end
endmodule
